muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 rs1_data_i  in  32  operand A (forwarded rs1).
REQ-004 rs2_data_i  in  32  operand B (forwarded rs2).
REQ-005 funct3  in  m_funct3_t(3)  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 m_alu_active  in  1  EX holds an M-extension op; stable with operands until accepted or flushed.
REQ-007 pipe_adv_i  in  1  EX/MEM buffer loads this cycle (result consumed).
REQ-008 flush_i  in  1  EX contents squashed (branch taken).
REQ-009 m_ex_alu_done  out  1  low = EX must stall; high = result valid or unit unused.
REQ-010 rd_data_o  out  32  32-bit result, valid when done is high and state is DONE.

Function
REQ-011 FSM states: IDLE, BUSY, DONE.
REQ-012 IDLE: done = ~m_alu_active (combinational); rd_data_o = 0.
REQ-013 IDLE & active & ~flush_i: capture operand magnitudes, result signs, funct3; load 6-bit counter with 32; go BUSY.
REQ-014 BUSY: one iteration per cycle, counter decrements; done = 0; at counter==1 go DONE.
REQ-015 DONE: done = 1; result held stable; pipe_adv_i -> IDLE.
REQ-016 Latency: active sampled at cycle 0; iterative op gives done high in cycle 33; fast-path op gives done high in cycle 1.
REQ-017 Back-to-back: next op is accepted no earlier than the cycle after the DONE->IDLE transition; no op is recomputed while DONE is held.
REQ-018 Multiply: 32-step shift-add on 32-bit magnitudes into a 64-bit product; negate if the sign flag is set. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32]. MULHSU: only rs1 is signed.
REQ-019 Divide: 32-step restoring division on magnitudes. Quotient sign = sA^sB (signed ops only); remainder sign = sA.
REQ-020 Divide by zero (rs2 == 0) is a fast path: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1.
REQ-021 Signed overflow (DIV/REM, rs1 = 0x80000000, rs2 = 0xFFFFFFFF) is a fast path: DIV = 0x80000000; REM = 0.
REQ-022 flush_i in any state: go IDLE next cycle, discard the result; flush has priority over pipe_adv_i and over start.
REQ-023 Operands and funct3 are ignored after capture; mid-op input changes do not affect the result.
REQ-024 m_alu_active deasserted in BUSY without flush_i is illegal; the unit continues the op to DONE.

Reset
REQ-025 rst: state IDLE; counter, operand, accumulator and result registers = 0; m_ex_alu_done = 1 (active low); rd_data_o = 0.
REQ-026 rst mid-op aborts the op with no result retained; the first op after rst release starts a fresh capture.

Configuration
REQ-027 MULDIV_SINGLE_CYCLE_MUL_EN defined: all multiplies use a 33x33 signed combinational product captured in IDLE; IDLE->DONE directly, done high in cycle 1.
REQ-028 MULDIV_SINGLE_CYCLE_MUL_EN undefined: multiplies use REQ-018, latency 33; divide behaviour is identical in both builds.

Structure
REQ-029 m_funct3_t and muldiv_state_t (IDLE/BUSY/DONE) live in rv32i_types.
REQ-030 The iteration width (32) and counter reload are package constants.
REQ-031 Sub-module muldiv_sign_fixup: combinational conditional two's-complement of quotient, remainder or 64-bit product per op and sign flags.

Verification
REQ-032 MUL 0x00000007 x 0xFFFFFFFD -> 0xFFFFFFEB; done low cycles 0-32, high cycle 33 (cycle 1 with macro).
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all done in cycle 33.
REQ-035 DIV/REM by 0 with rs1 = 0x1234 -> 0xFFFFFFFF / 0x1234; DIV 0x80000000/-1 -> 0x80000000; REM -> 0; all done in cycle 1.
REQ-036 flush_i at BUSY cycle 10 -> IDLE next cycle; a new DIVU 9/3 then gives 3 at its own cycle 33 with no stale result.
REQ-037 DONE held 5 cycles with pipe_adv_i low -> done and rd_data_o stable, no restart; rst asserted mid-BUSY -> IDLE, done = 1 immediately.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the M-extension multiply/divide unit.
package rv32i_types;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } m_funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   localparam int unsigned MULDIV_ITERS      = 32;
   localparam logic [5:0]  MULDIV_CNT_RELOAD = 6'(MULDIV_ITERS);

   function automatic logic is_div_op(input m_funct3_t op);
      return op[2];
   endfunction

   function automatic logic rs1_is_signed(input m_funct3_t op);
      return (op == F3_MUL) || (op == F3_MULH) || (op == F3_MULHSU) ||
             (op == F3_DIV) || (op == F3_REM);
   endfunction

   function automatic logic rs2_is_signed(input m_funct3_t op);
      return (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Applies the captured sign flags to the raw magnitude result and selects
// the 32-bit slice the instruction returns.
module muldiv_sign_fixup
   import rv32i_types::*;
(
   input  m_funct3_t   op,
   input  logic        neg_prod,
   input  logic        neg_quo,
   input  logic        neg_rem,
   input  logic [63:0] acc,
   output logic [31:0] result
);

   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;

   // acc holds {hi, lo} of the product, or {remainder, quotient} for divides
   always_comb begin
      prod   = neg_prod ? -acc : acc;
      quo    = neg_quo ? -acc[31:0] : acc[31:0];
      rem    = neg_rem ? -acc[63:32] : acc[63:32];
      result = rem;
      case (op)
         F3_MUL:                       result = prod[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result = prod[63:32];
         F3_DIV, F3_DIVU:              result = quo;
         default:                      result = rem;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with EX-stage stall handshake.
// MULDIV_SINGLE_CYCLE_MUL_EN selects a combinational multiplier; divides stay iterative.
//
//   state | meaning
//   IDLE  | no op in flight; done = ~m_alu_active
//   BUSY  | one shift-add / restoring-divide step per cycle, counter counts down
//   DONE  | result held on rd_data_o until pipe_adv_i or flush_i
module muldiv_unit
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  m_funct3_t   funct3,
   input  logic        m_alu_active,
   input  logic        pipe_adv_i,
   input  logic        flush_i,
   output logic        m_ex_alu_done,
   output logic [31:0] rd_data_o
);

   muldiv_state_t state_q, state_d;
   logic [5:0]    cnt_q;
   logic [63:0]   acc_q;
   logic [63:0]   acc_step;
   logic [31:0]   opb_q;
   logic [31:0]   result_q;
   m_funct3_t     op_q;
   logic          neg_q;
   logic          neg_rem_q;

   logic          sgn_a, sgn_b;
   logic [31:0]   mag_a, mag_b;
   logic          div_by_zero, div_ovf;
   logic          fast_path;
   logic [31:0]   fast_result;
   logic [31:0]   fix_result;
   logic          start, fsm_done;
   logic [32:0]   mul_sum, div_shift, div_diff;

   // operand decode at capture time
   always_comb begin
      sgn_a       = rs1_is_signed(funct3) & rs1_data_i[31];
      sgn_b       = rs2_is_signed(funct3) & rs2_data_i[31];
      mag_a       = sgn_a ? -rs1_data_i : rs1_data_i;
      mag_b       = sgn_b ? -rs2_data_i : rs2_data_i;
      div_by_zero = is_div_op(funct3) && (rs2_data_i == 32'd0);
      div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
   end

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
   logic [63:0] sc_a, sc_b, sc_prod;

   // low 64 bits of the 33x33 signed product; extension to 64 keeps it modular
   always_comb begin
      sc_a      = rs1_is_signed(funct3) ? {{32{rs1_data_i[31]}}, rs1_data_i} : {32'd0, rs1_data_i};
      sc_b      = rs2_is_signed(funct3) ? {{32{rs2_data_i[31]}}, rs2_data_i} : {32'd0, rs2_data_i};
      sc_prod   = sc_a * sc_b;
      fast_path = div_by_zero | div_ovf | ~is_div_op(funct3);
      if (!is_div_op(funct3))
         fast_result = (funct3 == F3_MUL) ? sc_prod[31:0] : sc_prod[63:32];
      else if (div_by_zero)
         fast_result = funct3[1] ? rs1_data_i : 32'hFFFF_FFFF;
      else
         fast_result = funct3[1] ? 32'd0 : 32'h8000_0000;
   end
`else
   always_comb begin
      fast_path = div_by_zero | div_ovf;
      if (div_by_zero)
         fast_result = funct3[1] ? rs1_data_i : 32'hFFFF_FFFF;
      else
         fast_result = funct3[1] ? 32'd0 : 32'h8000_0000;
   end
`endif

   // one iteration: multiply shifts the multiplier out of acc[31:0],
   // divide shifts the dividend into the partial remainder at acc[63:32]
   always_comb begin
      mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
      div_shift = acc_q[63:31];
      div_diff  = div_shift - {1'b0, opb_q};
      acc_step  = {mul_sum, acc_q[31:1]};
      if (is_div_op(op_q)) begin
         if (div_diff[32])
            acc_step = {div_shift[31:0], acc_q[30:0], 1'b0};
         else
            acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
      end
   end

   muldiv_sign_fixup u_fixup (
      .op       (op_q),
      .neg_prod (neg_q),
      .neg_quo  (neg_q),
      .neg_rem  (neg_rem_q),
      .acc      (acc_step),
      .result   (fix_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      fsm_done = 1'b0;
      start    = 1'b0;
      case (state_q)
         IDLE: begin
            fsm_done = ~m_alu_active;
            if (m_alu_active && !flush_i) begin
               start   = 1'b1;
               state_d = fast_path ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (flush_i)
               state_d = IDLE;
            else if (cnt_q == 6'd1)
               state_d = DONE;
         end
         DONE: begin
            fsm_done = 1'b1;
            if (flush_i || pipe_adv_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         result_q  <= '0;
         op_q      <= F3_MUL;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (flush_i) begin
         result_q <= '0;
      end else if (start) begin
         op_q      <= funct3;
         opb_q     <= mag_b;
         acc_q     <= {32'd0, mag_a};
         cnt_q     <= MULDIV_CNT_RELOAD;
         neg_q     <= sgn_a ^ sgn_b;
         neg_rem_q <= sgn_a;
         if (fast_path)
            result_q <= fast_result;
      end else if (state_q == BUSY) begin
         acc_q <= acc_step;
         cnt_q <= cnt_q - 6'd1;
         if (cnt_q == 6'd1)
            result_q <= fix_result;
      end
   end

   // reset forces "not stalling" even if EX still holds an M-op
   assign m_ex_alu_done = rst | fsm_done;
   assign rd_data_o     = (state_q == DONE) ? result_q : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// ops against an arithmetic reference model.
module tb_muldiv_unit;
   import rv32i_types::*;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
   localparam bit SC_MUL = 1'b1;
`else
   localparam bit SC_MUL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   m_funct3_t   funct3 = F3_MUL;
   logic        active = 1'b0;
   logic        pipe_adv = 1'b0;
   logic        flush = 1'b0;
   logic        done;
   logic [31:0] rd;

   int n_vec = 0;
   int n_err = 0;

   muldiv_unit dut (
      .clk           (clk),
      .rst           (rst),
      .rs1_data_i    (rs1),
      .rs2_data_i    (rs2),
      .funct3        (funct3),
      .m_alu_active  (active),
      .pipe_adv_i    (pipe_adv),
      .flush_i       (flush),
      .m_ex_alu_done (done),
      .rd_data_o     (rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return SC_MUL ? 1 : 33;
      if (b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // called at a negedge with the unit idle; returns at a negedge, unit idle
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold, input bit scramble);
      int lat;
      lat    = exp_lat(f3, a, b);
      rs1    = a;
      rs2    = b;
      funct3 = m_funct3_t'(f3);
      active = 1'b1;
      #1 chk("done_cycle0", {31'd0, done}, 32'd0);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         chk((c == lat) ? "done_rise" : "done_stall", {31'd0, done}, (c == lat) ? 32'd1 : 32'd0);
         if (scramble) begin
            rs1    = $urandom;
            rs2    = $urandom;
            funct3 = m_funct3_t'($urandom_range(0, 7));
         end
      end
      chk("result", rd, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_done", {31'd0, done}, 32'd1);
         chk("hold_result", rd, exp);
      end
      pipe_adv = 1'b1;
      active   = 1'b0;
      @(negedge clk);
      pipe_adv = 1'b0;
      chk("idle_done", {31'd0, done}, 32'd1);
      chk("idle_rd", rd, 32'd0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;

      repeat (2) @(negedge clk);
      chk("rst_done", {31'd0, done}, 32'd1);
      chk("rst_rd", rd, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", {31'd0, done}, 32'd1);

      // multiply corners
      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5, 1'b0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1'b0);

      // divide corners
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 0, 1'b1);
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 3, 1'b0);
      run_op(3'd4, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(3'd6, 32'h0000_1234, 32'd0, 32'h0000_1234, 0, 1'b0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);

      // flush during BUSY, then a fresh op with no stale result
      rs1 = 32'd100; rs2 = 32'd7; funct3 = F3_DIVU; active = 1'b1;
      repeat (10) @(negedge clk);
      chk("flush_pre_busy", {31'd0, done}, 32'd0);
      flush = 1'b1; active = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_idle_done", {31'd0, done}, 32'd1);
      chk("flush_idle_rd", rd, 32'd0);
      run_op(3'd5, 32'd9, 32'd3, 32'd3, 0, 1'b0);

      // flush wins over start in IDLE
      rs1 = 32'd9; rs2 = 32'd0; funct3 = F3_DIV; active = 1'b1; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; active = 1'b0;
      #1 chk("flush_blocks_start", {31'd0, done}, 32'd1);
      chk("flush_blocks_rd", rd, 32'd0);
      @(negedge clk);

      // reset mid-BUSY
      rs1 = 32'd1000; rs2 = 32'd3; funct3 = F3_DIVU; active = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1 chk("midop_rst_done", {31'd0, done}, 32'd1);
      chk("midop_rst_rd", rd, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 0, 1'b0);

      // randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op(f3, a, b, ref_model(f3, a, b), $urandom_range(0, 2), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
